myiram_prog: RTL and testbench

//  Parametrised, host-loadable instruction memory for the single-cycle CPU.
//  - CPU side: asynchronous word fetch from a byte address.
//  - Host side: byte-stream loader (valid/ready) and a bulk-clear sweep, so programs load at run time.
//  - Sits between the PC/fetch path and a host/UART byte source.

---
 rtl/iram_pkg.sv | 24 ++
 rtl/iram_byte_assembler.sv | 59 +++++
 rtl/myiram_prog.sv | 152 +++++++++++++++
 tb/tb_myiram_prog.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/iram_pkg.sv
// Shared types, constants and helpers for the host-loadable instruction memory.
package iram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } iram_state_t;

  // All-zero instruction; sliced down to IW at the point of use.
  localparam logic [255:0] IRAM_NOP = '0;

  // Ceiling log2, usable in parameter and port-width expressions.
  function automatic int iram_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/iram_byte_assembler.sv
// Collects host bytes into an instruction word. The word presented on WORD
// already contains the byte being accepted this cycle, so the parent can write
// it on the same edge; unfilled lanes read as zero.
module iram_byte_assembler
  import iram_pkg::*;
#(
  parameter int IW         = 16,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          accept,
  input  logic [7:0]    byte_in,
  input  logic          last,
  output logic [IW-1:0] word,
  output logic          word_valid
);

  localparam int LANES = IW / 8;
  localparam int LW    = (LANES > 1) ? iram_clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  logic [LW-1:0] lane;
  logic [IW-1:0] asm_q;

  // Merge the incoming byte into its lane on top of the bytes held so far.
  always_comb begin
    word = asm_q;
    for (int i = 0; i < LANES; i++) begin
      if (accept && (lane == LW'(i))) begin
        if (BIG_ENDIAN) word[(LANES-1-i)*8 +: 8] = byte_in;
        else            word[i*8 +: 8]           = byte_in;
      end
    end
  end

  assign word_valid = accept && ((lane == LAST_LANE) || last);

  // Lane counter and partial-word register; both clear once a word is emitted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane  <= '0;
      asm_q <= '0;
    end else if (flush) begin
      lane  <= '0;
      asm_q <= '0;
    end else if (accept) begin
      if (word_valid) begin
        lane  <= '0;
        asm_q <= '0;
      end else begin
        lane  <= lane + LW'(1);
        asm_q <= word;
      end
    end
  end

endmodule

// File: rtl/myiram_prog.sv
// Host-loadable instruction memory: combinational CPU fetch, byte-stream
// loader and a zeroing sweep, sequenced by a small control FSM.
module myiram_prog
  import iram_pkg::*;
#(
  parameter int IW         = 16,
  parameter int AW         = 8,
  parameter int DEPTH      = 128,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic [AW-1:0]                    ADDR,
  output logic [IW-1:0]                    Q,
  output logic                             MISALIGN,
  output logic                             BUSY,
  input  logic                             LD_START,
  input  logic [AW-1:0]                    LD_BASE,
  input  logic                             LD_VALID,
  input  logic [7:0]                       LD_DATA,
  input  logic                             LD_LAST,
  output logic                             LD_READY,
  input  logic                             CLR_START,
  output logic                             LD_DONE,
  output logic [iram_clog2(DEPTH+1)-1:0]   LD_COUNT
);

  localparam int CW = iram_clog2(DEPTH + 1);
  localparam int PW = AW - 1;
  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

  if (IW % 8 != 0) begin : g_bad_iw
    $error("myiram_prog: IW must be a multiple of 8");
  end
  if (DEPTH > (2 ** (AW - 1))) begin : g_bad_depth
    $error("myiram_prog: DEPTH exceeds the word range of AW");
  end

  iram_state_t   state;
  logic [PW-1:0] ptr;
  logic [IW-1:0] mem [DEPTH];

  logic          accept;
  logic          flush;
  logic [IW-1:0] asm_word;
  logic          asm_valid;
  logic          mem_we;
  logic [IW-1:0] mem_wdata;
  logic          ptr_ok;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] idx;
  logic          fetch_ok;
  logic          unused_base_lsb;

  assign unused_base_lsb = LD_BASE[0];

  assign accept = LD_VALID && LD_READY;
  // A new load starts with an empty lane; a simultaneous clear request wins.
  assign flush  = (state == IDLE) && LD_START && !CLR_START;

  iram_byte_assembler #(
    .IW         (IW),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_asm (
    .clk        (CLK),
    .rst        (RESET),
    .flush      (flush),
    .accept     (accept),
    .byte_in    (LD_DATA),
    .last       (LD_LAST),
    .word       (asm_word),
    .word_valid (asm_valid)
  );

  assign ptr_ok    = ({1'b0, ptr} < AW'(DEPTH));
  assign ptr_next  = (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
  assign mem_we    = ptr_ok && (((state == LOAD) && asm_valid) || (state == CLEAR));
  assign mem_wdata = (state == CLEAR) ? IRAM_NOP[IW-1:0] : asm_word;

  // Control FSM with registered BUSY / LD_READY / LD_DONE and pointer/count state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      ptr      <= '0;
      LD_COUNT <= '0;
      BUSY     <= 1'b0;
      LD_READY <= 1'b0;
      LD_DONE  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          LD_DONE <= 1'b0;
          if (CLR_START) begin
            state    <= CLEAR;
            ptr      <= '0;
            BUSY     <= 1'b1;
            LD_READY <= 1'b0;
          end else if (LD_START) begin
            state    <= LOAD;
            ptr      <= LD_BASE[AW-1:1];
            LD_COUNT <= '0;
            BUSY     <= 1'b1;
            LD_READY <= 1'b1;
          end
        end
        LOAD: begin
          if (asm_valid) begin
            ptr <= ptr_next;
            if (LD_COUNT != COUNT_MAX) LD_COUNT <= LD_COUNT + CW'(1);
            if (LD_LAST) begin
              state    <= DONE;
              BUSY     <= 1'b0;
              LD_READY <= 1'b0;
              LD_DONE  <= 1'b1;
            end
          end
        end
        CLEAR: begin
          if (ptr == PTR_LAST) begin
            state   <= DONE;
            BUSY    <= 1'b0;
            LD_DONE <= 1'b1;
          end else begin
            ptr <= ptr_next;
          end
        end
        DONE: begin
          state   <= IDLE;
          LD_DONE <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          BUSY     <= 1'b0;
          LD_READY <= 1'b0;
          LD_DONE  <= 1'b0;
        end
      endcase
    end
  end

  // Memory write port shared by the loader and the clear sweep; contents are not reset.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[ptr] <= mem_wdata;
  end

  assign idx      = ADDR[AW-1:1];
  assign fetch_ok = ({1'b0, idx} < AW'(DEPTH));
  assign MISALIGN = ADDR[0];
  assign Q        = (!BUSY && fetch_ok) ? mem[idx] : IRAM_NOP[IW-1:0];

endmodule

// File: tb/tb_myiram_prog.sv
// Directed bench for myiram_prog: a big-endian and a little-endian instance
// share all inputs; checks are immediate assertions with hand-computed values.
module tb_myiram_prog;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [7:0]  ADDR = '0;
  logic        LD_START = 1'b0;
  logic [7:0]  LD_BASE = '0;
  logic        LD_VALID = 1'b0;
  logic [7:0]  LD_DATA = '0;
  logic        LD_LAST = 1'b0;
  logic        CLR_START = 1'b0;

  logic [15:0] Q, le_q;
  logic        MISALIGN, BUSY, LD_READY, LD_DONE;
  logic        le_misalign, le_busy, le_ready, le_done;
  logic [7:0]  LD_COUNT, le_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  myiram_prog #(.IW(16), .AW(8), .DEPTH(128), .BIG_ENDIAN(1'b1)) u_be (
    .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .Q(Q), .MISALIGN(MISALIGN), .BUSY(BUSY),
    .LD_START(LD_START), .LD_BASE(LD_BASE), .LD_VALID(LD_VALID), .LD_DATA(LD_DATA),
    .LD_LAST(LD_LAST), .LD_READY(LD_READY), .CLR_START(CLR_START), .LD_DONE(LD_DONE),
    .LD_COUNT(LD_COUNT)
  );

  myiram_prog #(.IW(16), .AW(8), .DEPTH(128), .BIG_ENDIAN(1'b0)) u_le (
    .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .Q(le_q), .MISALIGN(le_misalign), .BUSY(le_busy),
    .LD_START(LD_START), .LD_BASE(LD_BASE), .LD_VALID(LD_VALID), .LD_DATA(LD_DATA),
    .LD_LAST(LD_LAST), .LD_READY(le_ready), .CLR_START(CLR_START), .LD_DONE(le_done),
    .LD_COUNT(le_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    LD_VALID = 1'b1;
    LD_DATA  = b;
    LD_LAST  = last;
    tick();
    LD_VALID = 1'b0;
    LD_LAST  = 1'b0;
  endtask

  task automatic start_load(input logic [7:0] base);
    LD_BASE  = base;
    LD_START = 1'b1;
    tick();
    LD_START = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [7:0] a, input logic [15:0] be_exp,
                       input logic [15:0] le_exp);
    ADDR = a;
    #1;
    chk({tag, "_be"}, 32'(Q), 32'(be_exp));
    chk({tag, "_le"}, 32'(le_q), 32'(le_exp));
  endtask

  initial begin
    int busy_cycles;
    int done_pulses;
    int bad_fetch;
    bit got_done;

    // Reset
    tick();
    tick();
    chk("rst_busy",  32'(BUSY), 32'd0);
    chk("rst_ready", 32'(LD_READY), 32'd0);
    chk("rst_done",  32'(LD_DONE), 32'd0);
    chk("rst_count", 32'(LD_COUNT), 32'd0);
    RESET = 1'b0;
    tick();

    // Case 1: clear sweep
    CLR_START = 1'b1;
    tick();
    CLR_START = 1'b0;
    chk("clr_busy", 32'(BUSY), 32'd1);
    chk("clr_ready", 32'(LD_READY), 32'd0);
    busy_cycles = 0;
    done_pulses = 0;
    for (int i = 0; i < 200; i++) begin
      if (BUSY) busy_cycles++;
      if (LD_DONE) done_pulses++;
      tick();
    end
    chk("clr_busy_cycles", 32'(busy_cycles), 32'd128);
    chk("clr_done_pulses", 32'(done_pulses), 32'd1);
    bad_fetch = 0;
    for (int a = 0; a < 256; a += 2) begin
      ADDR = 8'(a);
      #1;
      if (Q !== 16'h0000) bad_fetch++;
    end
    chk("clr_all_zero", 32'(bad_fetch), 32'd0);

    // Case 2: load at 0x10, big-endian F000 / 547F
    start_load(8'h10);
    chk("ld2_ready", 32'(LD_READY), 32'd1);
    chk("ld2_busy", 32'(BUSY), 32'd1);
    send(8'hF0, 1'b0);
    send(8'h00, 1'b0);
    chk("ld2_count_mid", 32'(LD_COUNT), 32'd1);
    send(8'h54, 1'b0);
    send(8'h7F, 1'b1);
    chk("ld2_done", 32'(LD_DONE), 32'd1);
    chk("ld2_busy_done", 32'(BUSY), 32'd0);
    chk("ld2_count", 32'(LD_COUNT), 32'd2);
    tick();
    chk("ld2_done_clr", 32'(LD_DONE), 32'd0);
    fetch("ld2_w8", 8'h10, 16'hF000, 16'h00F0);
    fetch("ld2_w9", 8'h12, 16'h547F, 16'h7F54);

    // Case 6: misaligned fetch returns the containing word
    ADDR = 8'h13;
    #1;
    chk("mis_flag", 32'(MISALIGN), 32'd1);
    chk("mis_q", 32'(Q), 32'h547F);
    ADDR = 8'h12;
    #1;
    chk("aligned_flag", 32'(MISALIGN), 32'd0);

    // Case 3: wrap from word 127 to word 0; fetch is NOP while busy
    start_load(8'hFE);
    ADDR = 8'h12;
    #1;
    chk("busy_fetch_nop", 32'(Q), 32'h0000);
    send(8'hAA, 1'b0);
    LD_LAST = 1'b1;
    tick();
    LD_LAST = 1'b0;
    chk("last_no_valid_busy", 32'(BUSY), 32'd1);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b0);
    send(8'hDD, 1'b1);
    chk("ld3_count", 32'(LD_COUNT), 32'd2);
    chk("ld3_done", 32'(LD_DONE), 32'd1);
    tick();
    fetch("ld3_w127", 8'hFE, 16'hAABB, 16'hBBAA);
    fetch("ld3_w0", 8'h00, 16'hCCDD, 16'hDDCC);

    // Case 4: odd byte count, last byte pads with zero
    start_load(8'h20);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    chk("ld4_not_done", 32'(LD_DONE), 32'd0);
    send(8'h33, 1'b1);
    chk("ld4_done", 32'(LD_DONE), 32'd1);
    chk("ld4_count", 32'(LD_COUNT), 32'd2);
    tick();
    fetch("ld4_w16", 8'h20, 16'h1122, 16'h2211);
    fetch("ld4_w17", 8'h22, 16'h3300, 16'h0033);

    // Case 5: async reset mid-word keeps memory, discards partial word
    start_load(8'h10);
    send(8'h99, 1'b0);
    RESET = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(BUSY), 32'd0);
    chk("rst_mid_ready", 32'(LD_READY), 32'd0);
    chk("rst_mid_count", 32'(LD_COUNT), 32'd0);
    tick();
    RESET = 1'b0;
    tick();
    fetch("rst_mid_w8", 8'h10, 16'hF000, 16'h00F0);

    // A fresh load after reset starts at lane 0
    start_load(8'h40);
    send(8'h12, 1'b0);
    send(8'h34, 1'b1);
    tick();
    fetch("post_rst_w32", 8'h40, 16'h1234, 16'h3412);

    // Clear wins over load when both start together
    CLR_START = 1'b1;
    LD_START  = 1'b1;
    LD_BASE   = 8'h10;
    tick();
    CLR_START = 1'b0;
    LD_START  = 1'b0;
    chk("both_busy", 32'(BUSY), 32'd1);
    chk("both_ready", 32'(LD_READY), 32'd0);
    got_done = 1'b0;
    for (int i = 0; i < 300 && !got_done; i++) begin
      if (LD_DONE) got_done = 1'b1;
      else tick();
    end
    chk("both_done_seen", 32'(got_done), 32'd1);
    chk("both_count_kept", 32'(LD_COUNT), 32'd1);
    tick();
    fetch("both_w8", 8'h10, 16'h0000, 16'h0000);
    fetch("both_w0", 8'h00, 16'h0000, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
